// File: rtl/mlab_fifo_ctrl_pkg.sv
// Sizing helpers shared by the MLAB FIFO controller, its bus interface and
// the MLAB storage model.
package mlab_fifo_pkg;

    // Pointer width: one extra MSB distinguishes full from empty across wrap.
    function automatic int unsigned ptr_w(input int unsigned aw);
        return aw + 1;
    endfunction

    // Number of words held by the MLAB.
    function automatic int unsigned depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/mlab_fifo_ctrl_if.sv
// Streaming bus of the MLAB FIFO: write side, show-ahead read side and fill level.
interface mlab_fifo_ctrl_if
    import mlab_fifo_pkg::*;
#(
    parameter int unsigned WIDTH      = 20,
    parameter int unsigned ADDR_WIDTH = 5
) ();

    logic [WIDTH-1:0]            din;
    logic                        din_valid;
    logic                        din_ready;
    logic [WIDTH-1:0]            dout;
    logic                        dout_valid;
    logic                        dout_ready;
    logic [ptr_w(ADDR_WIDTH):0]  occupancy;

    // FIFO side
    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_valid, occupancy
    );

    // Producer/consumer side
    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid, occupancy
    );

endinterface

// File: rtl/mlab_fifo_ctrl_mlab.sv
// Simple dual-port MLAB: registered write port, combinational read port.
// Contents are never cleared.
module alt_mlab
    import mlab_fifo_pkg::*;
#(
    parameter int unsigned WIDTH       = 20,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter bit          SIM_EMULATE = 1'b0
) (
    input  logic                  wclk,
    input  logic                  wena,
    input  logic [ADDR_WIDTH-1:0] waddr_reg,
    input  logic [WIDTH-1:0]      wdata_reg,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      dout
);

    localparam int unsigned DEPTH = depth(ADDR_WIDTH);

    generate
        if (SIM_EMULATE) begin : g_sim
            logic [WIDTH-1:0] mem [0:DEPTH-1];

            // Behavioural storage write
            always_ff @(posedge wclk) begin
                if (wena) mem[waddr_reg] <= wdata_reg;
            end

            assign dout = mem[raddr];
        end else begin : g_mlab
            (* ramstyle = "MLAB, no_rw_check" *) logic [WIDTH-1:0] mem [0:DEPTH-1];

            // MLAB-mapped storage write
            always_ff @(posedge wclk) begin
                if (wena) mem[waddr_reg] <= wdata_reg;
            end

            assign dout = mem[raddr];
        end
    endgenerate

endmodule

// File: rtl/mlab_fifo_ctrl.sv
// Single-clock show-ahead FIFO around one alt_mlab. Writes are registered
// into the MLAB one cycle after acceptance and only become readable once
// committed (cptr); the head word is held in an output register.
module mlab_fifo_ctrl
    import mlab_fifo_pkg::*;
#(
    parameter int unsigned WIDTH       = 20,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter bit          SIM_EMULATE = 1'b0
) (
    input  logic              clk,
    input  logic              sclr,
    mlab_fifo_ctrl_if.slave   bus
);

    localparam int unsigned   PW      = ptr_w(ADDR_WIDTH);
    localparam logic [PW-1:0] DEPTH_P = PW'(depth(ADDR_WIDTH));
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0]         wptr, cptr, rptr;
    logic [PW-1:0]         fill;
    logic                  wena_r;
    logic [ADDR_WIDTH-1:0] waddr_reg;
    logic [WIDTH-1:0]      wdata_reg;
    logic [WIDTH-1:0]      rdata;
    logic [WIDTH-1:0]      dout_r;
    logic                  dout_valid_r;
    logic                  push, pop, avail, load;

    assign fill  = wptr - rptr;
    assign push  = bus.din_valid & bus.din_ready;
    assign pop   = dout_valid_r & bus.dout_ready;
    assign avail = (cptr != rptr);
    assign load  = avail & (~dout_valid_r | bus.dout_ready);

    assign bus.din_ready  = (fill != DEPTH_P);
    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.occupancy  = {1'b0, fill} + {{PW{1'b0}}, dout_valid_r};

    alt_mlab #(
        .WIDTH       (WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .SIM_EMULATE (SIM_EMULATE)
    ) u_mlab (
        .wclk      (clk),
        .wena      (wena_r),
        .waddr_reg (waddr_reg),
        .wdata_reg (wdata_reg),
        .raddr     (rptr[ADDR_WIDTH-1:0]),
        .dout      (rdata)
    );

    // Pointer, write-staging and output-register update
    always_ff @(posedge clk) begin
        if (sclr) begin
            wptr         <= '0;
            cptr         <= '0;
            rptr         <= '0;
            wena_r       <= 1'b0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
        end else begin
            wena_r <= push;
            if (push) begin
                waddr_reg <= wptr[ADDR_WIDTH-1:0];
                wdata_reg <= bus.din;
                wptr      <= wptr + PTR_ONE;
            end
            if (wena_r) cptr <= cptr + PTR_ONE;
            if (load) begin
                dout_r       <= rdata;
                dout_valid_r <= 1'b1;
                rptr         <= rptr + PTR_ONE;
            end else if (pop) begin
                dout_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mlab_fifo_ctrl.sv
// Scoreboard bench for mlab_fifo_ctrl (WIDTH=20, ADDR_WIDTH=5, behavioural MLAB).
module tb_mlab_fifo_ctrl;

    localparam int unsigned W  = 20;
    localparam int unsigned AW = 5;

    logic clk  = 1'b0;
    logic sclr = 1'b1;

    mlab_fifo_ctrl_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

    mlab_fifo_ctrl #(
        .WIDTH       (W),
        .ADDR_WIDTH  (AW),
        .SIM_EMULATE (1'b1)
    ) dut (
        .clk  (clk),
        .sclr (sclr),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] sb [$];

    logic          s_dv, s_rdy;
    logic [W-1:0]  s_dout;
    logic [AW+1:0] s_occ;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive, snapshot outputs at negedge, record accepted word.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, output logic acc);
        bus.din_valid  = v;
        bus.din        = d;
        bus.dout_ready = r;
        @(negedge clk);
        s_dv   = bus.dout_valid;
        s_rdy  = bus.din_ready;
        s_dout = bus.dout;
        s_occ  = bus.occupancy;
        acc    = v & bus.din_ready;
        @(posedge clk);
        if (acc) sb.push_back(d);
        #1;
    endtask

    task automatic do_reset();
        bus.din_valid  = 1'b0;
        bus.din        = '0;
        bus.dout_ready = 1'b0;
        sclr = 1'b1;
        repeat (2) @(posedge clk);
        sb.delete();
        #1;
        sclr = 1'b0;
    endtask

    // Monitor: fill level versus words outstanding, ready rule, and data order
    always @(negedge clk) begin
        if (!sclr) begin
            chk("occupancy", 32'(bus.occupancy), sb.size());
            chk("occ_le_33", 32'(bus.occupancy <= 7'd33), 32'd1);
            if (bus.occupancy == 7'd33)
                chk("din_ready_full", 32'(bus.din_ready), 32'd0);
            else if (bus.occupancy <= 7'd31)
                chk("din_ready_space", 32'(bus.din_ready), 32'd1);
            if (bus.dout_valid && bus.dout_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL dout_unexpected: got 0x%0h, expected no valid word at %0t",
                             bus.dout, $time);
                end else begin
                    chk("dout", 32'(bus.dout), 32'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish, expected finish within 2ms");
        $fatal(1, "timeout");
    end

    initial begin
        logic a;
        int   acc_n;
        int   gaps;

        // 1: reset values, single word latency and pop
        do_reset();
        cycle(1'b1, 20'h00001, 1'b1, a);
        chk("rst_dout_valid", 32'(s_dv), 32'd0);
        chk("rst_occupancy", 32'(s_occ), 32'd0);
        chk("rst_din_ready", 32'(s_rdy), 32'd1);
        chk("rst_dout", 32'(s_dout), 32'd0);
        chk("t1_accept", 32'(a), 32'd1);
        cycle(1'b0, '0, 1'b1, a);
        chk("t1_dv_after_e0", 32'(s_dv), 32'd0);
        chk("t1_occ_after_e0", 32'(s_occ), 32'd1);
        cycle(1'b0, '0, 1'b1, a);
        chk("t1_dv_after_e1", 32'(s_dv), 32'd0);
        cycle(1'b0, '0, 1'b1, a);
        chk("t1_dv_after_e2", 32'(s_dv), 32'd1);
        chk("t1_dout", 32'(s_dout), 32'h00001);
        chk("t1_occ_after_e2", 32'(s_occ), 32'd1);
        cycle(1'b0, '0, 1'b1, a);
        chk("t1_dv_after_pop", 32'(s_dv), 32'd0);
        chk("t1_occ_after_pop", 32'(s_occ), 32'd0);

        // 2: fill to DEPTH+1 with consumer stalled, then drain in order
        do_reset();
        for (int i = 0; i < 33; i++) begin
            cycle(1'b1, W'(i), 1'b0, a);
            chk("t2_accept", 32'(a), 32'd1);
        end
        cycle(1'b1, W'(33), 1'b0, a);
        chk("t2_full_ready", 32'(s_rdy), 32'd0);
        chk("t2_full_occ", 32'(s_occ), 32'd33);
        chk("t2_full_no_accept", 32'(a), 32'd0);
        repeat (40) cycle(1'b0, '0, 1'b1, a);
        chk("t2_drained_occ", 32'(s_occ), 32'd0);

        // 3: sustained push+pop across pointer wrap
        do_reset();
        acc_n = 0;
        gaps  = 0;
        for (int i = 0; i < 200; i++) begin
            cycle(1'b1, W'(32'h100 + i), 1'b1, a);
            if (a) acc_n++;
            if (i >= 3 && !s_dv) gaps++;
        end
        chk("t3_accepts", 32'(acc_n), 32'd200);
        chk("t3_output_gaps", 32'(gaps), 32'd0);
        repeat (5) cycle(1'b0, '0, 1'b1, a);

        // 4: push and pop together while full
        do_reset();
        for (int i = 0; i < 33; i++) cycle(1'b1, W'(32'h200 + i), 1'b0, a);
        cycle(1'b1, 20'h00300, 1'b1, a);
        chk("t4_full_ready", 32'(s_rdy), 32'd0);
        chk("t4_full_no_accept", 32'(a), 32'd0);
        cycle(1'b1, 20'h00300, 1'b1, a);
        chk("t4_ready_next", 32'(s_rdy), 32'd1);
        chk("t4_accept_next", 32'(a), 32'd1);
        repeat (40) cycle(1'b0, '0, 1'b1, a);

        // 5: random traffic, 50% valid / 30% ready
        do_reset();
        for (int i = 0; i < 10000; i++)
            cycle(($urandom_range(0, 99) < 50), W'($urandom), ($urandom_range(0, 99) < 30), a);
        repeat (40) cycle(1'b0, '0, 1'b1, a);
        chk("t5_drained_occ", 32'(s_occ), 32'd0);

        // 6: reset with words held and a write in flight
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, W'(32'h400 + i), 1'b0, a);
        do_reset();
        cycle(1'b1, 20'hABCDE, 1'b1, a);
        chk("t6_dout_valid", 32'(s_dv), 32'd0);
        chk("t6_occupancy", 32'(s_occ), 32'd0);
        chk("t6_din_ready", 32'(s_rdy), 32'd1);
        chk("t6_dout", 32'(s_dout), 32'd0);
        chk("t6_accept", 32'(a), 32'd1);
        repeat (3) cycle(1'b0, '0, 1'b1, a);
        chk("t6_first_valid", 32'(s_dv), 32'd1);
        chk("t6_first_word", 32'(s_dout), 32'hABCDE);
        repeat (3) cycle(1'b0, '0, 1'b1, a);
        chk("t6_drained_occ", 32'(s_occ), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
